serializer: RTL
===============

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: parallel word width.
REQ-002 The block SHALL have parameter MOD_W, default 4: width of the length field, equal to $clog2(DATA_W).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, DATA_W bits: parallel word to transmit.
REQ-006 The block SHALL have port data_mod_i, input, MOD_W bits: number of valid bits, counted from the MSB.
REQ-007 The block SHALL have port data_val_i, input, 1 bit: data_i and data_mod_i are valid this cycle.
REQ-008 The block SHALL have port ser_data_o, output, 1 bit: serial data, feeding the data_i port of the downstream deserializer.
REQ-009 The block SHALL have port ser_data_val_o, output, 1 bit: ser_data_o is valid, feeding the data_val_i port of the downstream deserializer.
REQ-010 The block SHALL have port busy_o, output, 1 bit: a word is in transmission and new requests are not accepted.

Function
REQ-011 The block SHALL implement two states, IDLE and SHIFT.
REQ-012 In IDLE, the block SHALL accept a request on a rising edge where data_val_i=1 and the length is legal; it latches data_i and the length, then moves to SHIFT.
REQ-013 The length SHALL be decoded as: data_mod_i=0 means DATA_W bits; data_mod_i of 1 or 2 is illegal; any other value N means N bits.
REQ-014 An illegal request SHALL be dropped with no output activity; the block stays in IDLE.
REQ-015 The block SHALL send bits MSB first: data_i[DATA_W-1], then DATA_W-2, and so on, down to data_i[DATA_W-N].
REQ-016 Latency SHALL be fixed: the first bit and ser_data_val_o=1 appear in the cycle after the acceptance edge.
REQ-017 ser_data_val_o SHALL be high for exactly N consecutive cycles per accepted word, with no gaps.
REQ-018 busy_o SHALL equal ser_data_val_o, i.e. high exactly while in SHIFT.
REQ-019 data_val_i SHALL be ignored while busy_o=1, and the latched word SHALL be unaffected by input changes during SHIFT.
REQ-020 The block SHALL move SHIFT->IDLE on the edge that ends the last bit, tracked by a down-counter that reaches zero.
REQ-021 A new request MAY be accepted on that same edge only if busy_o was low; therefore the minimum inter-word gap is 1 idle cycle.
REQ-022 When ser_data_val_o=0, ser_data_o SHALL be driven to 0.
REQ-023 An accepted DATA_W-bit word SHALL be bit-exact with what the downstream deserializer reassembles, given MSB-first assembly.

Reset
REQ-024 When rst_n_i=0, the block SHALL asynchronously force state=IDLE, bit counter=0, shift register=0, ser_data_o=0, ser_data_val_o=0 and busy_o=0.
REQ-025 Asserting reset in the middle of a word SHALL abort it immediately; the partial word SHALL NOT resume after reset.
REQ-026 Reset release SHALL be synchronous to clk_i; the first request is accepted on the first rising edge where rst_n_i=1.

Structure
REQ-027 Package serializer_pkg SHALL hold DATA_W, MOD_W, the state enum (IDLE, SHIFT) and the illegal-length constants.
REQ-028 The block SHALL be a single module with no sub-module; the counter and shift register live inline.

Verification
REQ-029 Scenario full word: data_i=16'hA5C3, data_mod_i=0, one-cycle data_val_i -> ser_data_val_o high 16 cycles starting next cycle, bits 1010_0101_1100_0011, busy_o tracks ser_data_val_o.
REQ-030 Scenario partial word: data_i=16'hF000, data_mod_i=5 -> 5 valid cycles carrying 1,1,1,1,0; busy_o drops after the 5th.
REQ-031 Scenario illegal length: data_mod_i=1, then data_mod_i=2 -> ser_data_val_o and busy_o stay 0 for 20 cycles.
REQ-032 Scenario busy ignore: word 16'hFFFF accepted, data_val_i with 16'h0000 held during SHIFT -> 16 ones only, no second word.
REQ-033 Scenario mid-word reset: pull rst_n_i low at bit 7 of 16'hFFFF -> all outputs 0 with no clock edge; after release, a new request 16'h0001 with data_mod_i=0 produces 15 zeros then a 1.
REQ-034 Scenario end-to-end: serializer drives the deserializer with 16'h1234, then 16'hBEEF, mod=0 -> deser_data_o equals 16'h1234, then 16'hBEEF, with no errors.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer: default word geometry, the FSM state
// encoding and the length codes that are rejected on request.
package serializer_pkg;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);

  // Length codes 1 and 2 are reserved and never transmitted.
  localparam int MOD_ILLEGAL_1 = 1;
  localparam int MOD_ILLEGAL_2 = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first.
//
// Accepts a word plus a length code while idle and shifts out the top N bits,
// one per clock, with a valid strobe that feeds a downstream deserializer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a legal request; outputs held at 0
// SHIFT | transmitting latched word; bit_cnt counts remaining bits - 1
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_n_i        - asynchronous active-low reset
//   data_i         - parallel word to transmit
//   data_mod_i     - number of valid bits from the MSB (0 = full word)
//   data_val_i     - data_i / data_mod_i valid this cycle
//   ser_data_o     - serial data, 0 when not valid
//   ser_data_val_o - serial data valid
//   busy_o         - word in transmission, requests ignored
module serializer #(
  parameter int DATA_W = serializer_pkg::DATA_W,
  parameter int MOD_W  = serializer_pkg::MOD_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  import serializer_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [MOD_W-1:0]  bit_cnt;
  logic [MOD_W-1:0]  cnt_load;
  logic [DATA_W-1:0] shreg;
  logic              req_legal;
  logic              accept;

  assign req_legal = (data_mod_i != MOD_W'(MOD_ILLEGAL_1)) &&
                     (data_mod_i != MOD_W'(MOD_ILLEGAL_2));

  // Only sampled in IDLE, so a request arriving on the edge that ends the
  // last bit is ignored; this enforces the one-cycle minimum gap.
  assign accept = (state == IDLE) && data_val_i && req_legal;

  // Counter holds remaining bits minus one so terminal count is zero.
  assign cnt_load = (data_mod_i == '0) ? MOD_W'(DATA_W - 1)
                                       : data_mod_i - MOD_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= data_i;
      bit_cnt <= cnt_load;
    end else if (state == SHIFT) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
      if (bit_cnt != '0) bit_cnt <= bit_cnt - MOD_W'(1);
    end
  end

  assign ser_data_val_o = (state == SHIFT);
  assign busy_o         = (state == SHIFT);
  assign ser_data_o     = (state == SHIFT) & shreg[DATA_W-1];

endmodule
